// File: rtl/fpu_defs_fmac.sv
// Shared FMAC definitions: default formats, special-value constants
// and the per-operand class bundle used by the operand preprocessor.
package fpu_defs_fmac;

  localparam int unsigned C_FMAC_EXP  = 8;
  localparam int unsigned C_FMAC_MANT = 23;

  localparam logic [C_FMAC_EXP-1:0]  C_EXP_ZERO  = '0;
  localparam logic [C_FMAC_EXP-1:0]  C_EXP_ONE   = C_FMAC_EXP'(1);
  localparam logic [C_FMAC_EXP-1:0]  C_EXP_INF   = '1;
  localparam logic [C_FMAC_MANT-1:0] C_MANT_ZERO = '0;

  typedef struct packed {
    logic zero;
    logic inf;
    logic qnan;
    logic snan;
    logic den;
  } fmac_class_t;

endpackage

// File: rtl/fmac_lzc.sv
// Leading-zero counter; cnt saturates at WIDTH when the input is zero.
// Used by preprocess_fmac_pipe only with FMAC_PREPROC_DENORM_NORM_EN.
module fmac_lzc #(
  parameter  int unsigned WIDTH = 24,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CW-1:0]    cnt,
  output logic             all_zero
);

  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) cnt = CW'(WIDTH - 1 - i);
    end
  end

  assign all_zero = ~|data;

endmodule

// File: rtl/preprocess_fmac_pipe.sv
// Two-stage elastic FMAC operand preprocessor (decode + classify).
// FMAC_PREPROC_DENORM_NORM_EN: normalise denormals via LZC.
module preprocess_fmac_pipe
  import fpu_defs_fmac::*;
#(
  parameter  int unsigned C_EXP     = C_FMAC_EXP,
  parameter  int unsigned C_MANT    = C_FMAC_MANT,
  parameter  int unsigned C_NUM_OPS = 3,
  parameter  int unsigned C_TAG     = 4,
  localparam int unsigned C_OP      = C_EXP + C_MANT + 1
) (
  input  logic                             Clk_CI,
  input  logic                             Rst_RBI,
  input  logic                             Flush_SI,
  input  logic                             In_Valid_SI,
  output logic                             In_Ready_SO,
  input  logic [C_NUM_OPS*C_OP-1:0]        Operands_DI,
  input  logic [C_TAG-1:0]                 Tag_DI,
  output logic                             Out_Valid_SO,
  input  logic                             Out_Ready_SI,
  output logic [C_NUM_OPS-1:0]             Sign_DO,
  output logic [C_NUM_OPS*(C_EXP+1)-1:0]   Exp_DO,
  output logic [C_NUM_OPS*(C_MANT+1)-1:0]  Mant_DO,
  output logic [C_NUM_OPS-1:0]             Zero_SO,
  output logic [C_NUM_OPS-1:0]             Inf_SO,
  output logic [C_NUM_OPS-1:0]             QNaN_SO,
  output logic [C_NUM_OPS-1:0]             SNaN_SO,
  output logic [C_NUM_OPS-1:0]             DeN_SO,
  output logic                             AnyNaN_SO,
  output logic [C_TAG-1:0]                 Tag_DO
);

  localparam int unsigned C_EW = C_EXP + 1;
  localparam int unsigned C_MW = C_MANT + 1;

  logic v0, v1;
  logic rdy0, rdy1;
  logic ld0, ld1;

  logic [C_NUM_OPS-1:0]             d_sign, d_hb, d_mz, d_ez, d_eo;
  logic [C_NUM_OPS-1:0][C_EXP-1:0]  d_exp;
  logic [C_NUM_OPS-1:0][C_MANT-1:0] d_mant;

  logic [C_TAG-1:0]                 s0_tag;
  logic [C_NUM_OPS-1:0]             s0_sign, s0_hb, s0_mz, s0_ez, s0_eo;
  logic [C_NUM_OPS-1:0][C_EXP-1:0]  s0_exp;
  logic [C_NUM_OPS-1:0][C_MANT-1:0] s0_mant;

  fmac_class_t [C_NUM_OPS-1:0]      s1_cls_d, s1_cls;
  logic [C_NUM_OPS-1:0][C_EW-1:0]   s1_exp_d, s1_exp;
  logic [C_NUM_OPS-1:0][C_MW-1:0]   s1_mant_d, s1_mant;
  logic [C_NUM_OPS-1:0]             s1_sign;
  logic [C_TAG-1:0]                 s1_tag;

`ifdef FMAC_PREPROC_DENORM_NORM_EN
  localparam int unsigned C_LZW = $clog2(C_MW + 1);
  logic [C_NUM_OPS-1:0][C_LZW-1:0]  d_lzc, s0_lzc;
`endif

  assign rdy1        = ~v1 | Out_Ready_SI;
  assign rdy0        = ~v0 | rdy1;
  assign In_Ready_SO = rdy0;
  assign ld0         = In_Valid_SI & rdy0 & ~Flush_SI;
  assign ld1         = v0 & rdy1 & ~Flush_SI;

  for (genvar i = 0; i < C_NUM_OPS; i++) begin : g_dec
    logic [C_OP-1:0] op;
    assign op        = Operands_DI[i*C_OP +: C_OP];
    assign d_sign[i] = op[C_OP-1];
    assign d_exp[i]  = op[C_MANT +: C_EXP];
    assign d_mant[i] = op[C_MANT-1:0];
    assign d_hb[i]   = |d_exp[i];
    assign d_mz[i]   = d_mant[i] == C_MANT'(C_MANT_ZERO);
    assign d_ez[i]   = d_exp[i] == C_EXP'(C_EXP_ZERO);
    assign d_eo[i]   = &d_exp[i];
`ifdef FMAC_PREPROC_DENORM_NORM_EN
    logic [C_LZW-1:0] cnt;
    logic             all_zero;
    fmac_lzc #(.WIDTH(C_MW)) u_lzc (
      .data     ({d_hb[i], d_mant[i]}),
      .cnt      (cnt),
      .all_zero (all_zero)
    );
    // zero operands never shift, so keep their count clean
    assign d_lzc[i] = all_zero ? '0 : cnt;
`endif
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else if (Flush_SI) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else begin
      if (rdy0) v0 <= In_Valid_SI;
      if (rdy1) v1 <= v0;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      s0_tag  <= '0;
      s0_sign <= '0;
      s0_hb   <= '0;
      s0_mz   <= '0;
      s0_ez   <= '0;
      s0_eo   <= '0;
      s0_exp  <= '0;
      s0_mant <= '0;
`ifdef FMAC_PREPROC_DENORM_NORM_EN
      s0_lzc  <= '0;
`endif
    end else if (ld0) begin
      s0_tag  <= Tag_DI;
      s0_sign <= d_sign;
      s0_hb   <= d_hb;
      s0_mz   <= d_mz;
      s0_ez   <= d_ez;
      s0_eo   <= d_eo;
      s0_exp  <= d_exp;
      s0_mant <= d_mant;
`ifdef FMAC_PREPROC_DENORM_NORM_EN
      s0_lzc  <= d_lzc;
`endif
    end
  end

  for (genvar i = 0; i < C_NUM_OPS; i++) begin : g_cls
    logic [C_MW-1:0] mant_full;
    logic            den, nan;
    assign mant_full        = {s0_hb[i], s0_mant[i]};
    assign den              = s0_ez[i] & ~s0_mz[i];
    assign nan              = s0_eo[i] & ~s0_mz[i];
    assign s1_cls_d[i].zero = s0_ez[i] & s0_mz[i];
    assign s1_cls_d[i].inf  = s0_eo[i] & s0_mz[i];
    assign s1_cls_d[i].qnan = nan & s0_mant[i][C_MANT-1];
    assign s1_cls_d[i].snan = nan & ~s0_mant[i][C_MANT-1];
    assign s1_cls_d[i].den  = den;
`ifdef FMAC_PREPROC_DENORM_NORM_EN
    assign s1_mant_d[i] = den ? mant_full << s0_lzc[i] : mant_full;
    assign s1_exp_d[i]  = den ? C_EW'(C_EXP_ONE) - C_EW'(s0_lzc[i])
                              : {1'b0, s0_exp[i]};
`else
    assign s1_mant_d[i] = mant_full;
    assign s1_exp_d[i]  = den ? C_EW'(C_EXP_ONE) : {1'b0, s0_exp[i]};
`endif
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      s1_tag  <= '0;
      s1_sign <= '0;
      s1_exp  <= '0;
      s1_mant <= '0;
      s1_cls  <= '0;
    end else if (ld1) begin
      s1_tag  <= s0_tag;
      s1_sign <= s0_sign;
      s1_exp  <= s1_exp_d;
      s1_mant <= s1_mant_d;
      s1_cls  <= s1_cls_d;
    end
  end

  for (genvar i = 0; i < C_NUM_OPS; i++) begin : g_out
    assign Zero_SO[i] = s1_cls[i].zero;
    assign Inf_SO[i]  = s1_cls[i].inf;
    assign QNaN_SO[i] = s1_cls[i].qnan;
    assign SNaN_SO[i] = s1_cls[i].snan;
    assign DeN_SO[i]  = s1_cls[i].den;
  end

  assign Out_Valid_SO = v1;
  assign Sign_DO      = s1_sign;
  assign Exp_DO       = s1_exp;
  assign Mant_DO      = s1_mant;
  assign AnyNaN_SO    = |(QNaN_SO | SNaN_SO);
  assign Tag_DO       = s1_tag;

endmodule
